tt_sweep_ctrl: RTL and testbench

Sequencer that exhaustively sweeps all 2^N_IN input vectors through one of our combinational example networks, such as the 6-input layered logic cones. For each vector it waits a programmable settle time, samples the network output, streams each sample over a valid/ready port, and builds the full truth table plus a ones-count. It sits between the combinational network under evaluation and the visualisation/capture logic.

---
 rtl/tt_sweep_ctrl.sv | 73 +++++++
 tb/tb_tt_sweep_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: exhaustive input sweep of a combinational network, sampling each vector into a truth table and a ones count.
module tt_sweep_ctrl #(
  parameter int N_IN   = 6,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  output logic [N_IN-1:0]      vec,
  input  logic                 f_in,
  output logic                 samp_valid,
  input  logic                 samp_ready,
  output logic [N_IN-1:0]      samp_index,
  output logic                 samp_value,
  output logic                 busy,
  output logic                 done,
  output logic [(1<<N_IN)-1:0] truth_table,
  output logic [N_IN:0]        ones_count
);
  typedef enum logic [1:0] {IDLE, WAIT, EMIT, DONE} state_t;
  state_t state, state_n;
  logic [7:0] cnt;
  logic last, hs;
  assign last = vec == {N_IN{1'b1}};
  assign hs   = samp_valid & samp_ready;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_n = abort             ? IDLE :
              state == IDLE     ? (start ? WAIT : IDLE) :
              state == WAIT     ? (cnt == 8'd0 ? EMIT : WAIT) :
              state == EMIT     ? (hs ? (last ? DONE : WAIT) : EMIT) :
                                  IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      vec         <= '0;
      samp_valid  <= 1'b0;
      samp_index  <= '0;
      samp_value  <= 1'b0;
      truth_table <= '0;
      ones_count  <= '0;
    end else begin
      state <= state_n;
      if (abort) begin
        samp_valid <= 1'b0;
      end else if (state == IDLE && start) begin
        vec         <= '0;
        cnt         <= 8'(SETTLE);
        truth_table <= '0;
        ones_count  <= '0;
      end else if (state == WAIT && cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end else if (state == WAIT) begin
        truth_table[vec] <= f_in;
        ones_count       <= ones_count + {{N_IN{1'b0}}, f_in};
        samp_value       <= f_in;
        samp_index       <= vec;
        samp_valid       <= 1'b1;
      end else if (state == EMIT && hs) begin
        samp_valid <= 1'b0;
        // the final vector stays on vec so the sweep never wraps
        if (!last) begin
          vec <= vec + 1'b1;
          cnt <= 8'(SETTLE);
        end
      end
    end
  end
endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// tb_tt_sweep_ctrl: directed checks of tt_sweep_ctrl with SETTLE=0 and SETTLE=3 instances.
module tb_tt_sweep_ctrl;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, st0, ab0, rdy0, f0, st3;
  int mode;
  logic [5:0] vec0, si0, vec3, si3;
  logic sv0, sval0, busy0, done0, sv3, sval3, busy3, done3;
  logic [63:0] tt0, tt3;
  logic [6:0] oc0, oc3;
  int checks = 0, errors = 0;

  function automatic logic net(input logic [5:0] v);
    logic a, b, c, d, e, g, l1, l2, l3, l4, l5, l6, l7;
    {g, e, d, c, b, a} = v;
    l1 = a & b;
    l2 = c ^ d;
    l3 = l1 | e;
    l4 = l2 & ~g;
    l5 = l3 ^ l4;
    l6 = l5 | (a & g);
    l7 = l6 & ~(b & d);
    return l7 ^ (c & e);
  endfunction

  assign f0 = mode == 0 ? vec0[0] : net(vec0);

  tt_sweep_ctrl #(.N_IN(6), .SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(st0), .abort(ab0), .vec(vec0), .f_in(f0),
    .samp_valid(sv0), .samp_ready(rdy0), .samp_index(si0), .samp_value(sval0),
    .busy(busy0), .done(done0), .truth_table(tt0), .ones_count(oc0));

  tt_sweep_ctrl #(.N_IN(6), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(st3), .abort(1'b0), .vec(vec3), .f_in(1'b0),
    .samp_valid(sv3), .samp_ready(1'b1), .samp_index(si3), .samp_value(sval3),
    .busy(busy3), .done(done3), .truth_table(tt3), .ones_count(oc3));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  logic sel;
  int done_at, npulse, bp_idx, bp_left, inj;
  logic busy_after, stall_ok;
  logic [5:0] vec_at [0:400];

  task automatic start_sweep;
    @(negedge clk);
    if (sel) st3 = 1; else st0 = 1;
    @(negedge clk);
    st0 = 0;
    st3 = 0;
  endtask

  // starts at the negedge of cycle 1; cycle c is observed at its negedge
  task automatic watch(input int budget);
    logic stalled;
    done_at = -1; npulse = 0; busy_after = 1; stall_ok = 1; stalled = 0;
    for (int c = 1; c <= budget; c++) begin
      if (sel ? done3 : done0) begin
        npulse++;
        if (done_at < 0) done_at = c;
      end
      if (done_at >= 0 && c == done_at + 1) busy_after = sel ? busy3 : busy0;
      if (c <= 400) vec_at[c] = sel ? vec3 : vec0;
      if (stalled) stall_ok &= sv0 && si0 == bp_idx[5:0] && vec0 == bp_idx[5:0];
      stalled = 0;
      rdy0 = 1;
      if (!sel && bp_left > 0 && sv0 && si0 == bp_idx[5:0]) begin
        rdy0 = 0;
        bp_left--;
        stalled = 1;
      end
      st0 = !sel && c == inj;
      @(negedge clk);
    end
    rdy0 = 1;
    st0 = 0;
  endtask

  task automatic wait_for(input int which, input int val);
    int n = 0;
    while (!(which == 0 ? (sv0 && si0 == val[5:0]) : (vec0 == val[5:0])) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("wait_timeout", 0, 1);
  endtask

  logic [63:0] exp_tt;
  int exp_oc;

  initial begin
    rst = 1; st0 = 0; ab0 = 0; rdy0 = 1; st3 = 0; mode = 0; sel = 0;
    bp_idx = 0; bp_left = 0; inj = -1;
    repeat (2) @(negedge clk);
    check("rst_vec", 64'(vec0), 0);
    check("rst_valid", 64'(sv0), 0);
    check("rst_busy", 64'(busy0), 0);
    check("rst_done", 64'(done0), 0);
    check("rst_tt", tt0, 0);
    check("rst_oc", 64'(oc0), 0);
    rst = 0;

    // 1: f = a, no settle, ready tied high
    start_sweep;
    watch(200);
    check("s1_done_at", 64'(done_at), 129);
    check("s1_npulse", 64'(npulse), 1);
    check("s1_busy_after", 64'(busy_after), 0);
    check("s1_tt", tt0, 64'hAAAA_AAAA_AAAA_AAAA);
    check("s1_oc", 64'(oc0), 32);
    check("s1_last_value", 64'(sval0), 1);

    // 2: f = 0, SETTLE=3
    sel = 1;
    start_sweep;
    watch(400);
    check("s2_done_at", 64'(done_at), 321);
    check("s2_tt", tt3, 0);
    check("s2_oc", 64'(oc3), 0);
    check("s2_vec_c5", 64'(vec_at[5]), 0);
    check("s2_vec_c6", 64'(vec_at[6]), 1);
    check("s2_vec_c11", 64'(vec_at[11]), 2);
    check("s2_vec_c320", 64'(vec_at[320]), 63);
    sel = 0;

    // 3: ten cycles of backpressure on index 5
    bp_idx = 5; bp_left = 10;
    start_sweep;
    watch(220);
    check("s3_done_at", 64'(done_at), 139);
    check("s3_stall_hold", 64'(stall_ok), 1);
    check("s3_bp_used", 64'(bp_left), 0);
    check("s3_tt", tt0, 64'hAAAA_AAAA_AAAA_AAAA);

    // 4: abort while index 20 is offered
    start_sweep;
    wait_for(0, 20);
    ab0 = 1;
    @(negedge clk);
    ab0 = 0;
    check("s4_busy", 64'(busy0), 0);
    check("s4_valid", 64'(sv0), 0);
    check("s4_done", 64'(done0), 0);
    check("s4_tt", tt0, 64'h00000000000AAAAA);
    check("s4_oc", 64'(oc0), 10);
    repeat (3) @(negedge clk);
    check("s4_idle", 64'(busy0), 0);
    start_sweep;
    check("s4_restart_tt", tt0, 0);
    check("s4_restart_vec", 64'(vec0), 0);
    inj = 50;
    watch(200);
    inj = -1;
    check("s4_ignore_start", 64'(done_at), 129);
    check("s4_full_tt", tt0, 64'hAAAA_AAAA_AAAA_AAAA);

    // 5: reset at vec 40, then 6: full sweep of the example network
    start_sweep;
    wait_for(1, 40);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("s5_vec", 64'(vec0), 0);
    check("s5_valid", 64'(sv0), 0);
    check("s5_index", 64'(si0), 0);
    check("s5_busy", 64'(busy0), 0);
    check("s5_tt", tt0, 0);
    check("s5_oc", 64'(oc0), 0);
    mode = 1;
    exp_tt = 0;
    exp_oc = 0;
    for (int k = 0; k < 64; k++) begin
      exp_tt[k] = net(6'(k));
      exp_oc += int'(net(6'(k)));
    end
    start_sweep;
    watch(200);
    check("s6_done_at", 64'(done_at), 129);
    check("s6_tt", tt0, exp_tt);
    check("s6_oc", 64'(oc0), 64'(exp_oc));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
